// File: rtl/duty_pkg.sv
// rtl/duty_pkg.sv - shared state type, constants and clamp helper for duty_measure
package duty_pkg;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int DUTY_W    = 7;
  localparam int DUTY_MAX  = 100;
  localparam int DIV_STEPS = 7;
  localparam int DIV_LAT   = 9;

  // Quotient never reported above 100 percent
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] q);
    return (q > DUTY_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : q;
  endfunction

endpackage

// File: rtl/duty_div.sv
// rtl/duty_div.sv - restoring divider, 7 quotient bits MSB first; DUTY_ROUND_EN selects round-to-nearest
module duty_div
  import duty_pkg::*;
#(
  parameter int CNT_W = 26
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CNT_W+6:0]     num_i,
  input  logic [CNT_W-1:0]     den_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DUTY_W-1:0]    quo_o
);

  localparam int NUM_W = CNT_W + 7;

  logic [NUM_W-1:0]  rem_q, rem_d;
  logic [NUM_W-1:0]  dsh_q, dsh_d;
  logic [NUM_W-1:0]  num_adj;
  logic [DUTY_W-1:0] quo_q, quo_d;
  logic [3:0]        step_q, step_d;
  logic              busy_q, busy_d;

`ifdef DUTY_ROUND_EN
  // Half the divisor added up front turns the truncating divide into round-to-nearest
  assign num_adj = num_i + NUM_W'(den_i >> 1);
`else
  assign num_adj = num_i;
`endif

  // Steps 0..6 produce quotient bits, step 7 presents the result, step 8 covers the
  // cycle the top registers it, so a new start is refused until the result is visible.
  always_comb begin
    rem_d  = rem_q;
    dsh_d  = dsh_q;
    quo_d  = quo_q;
    step_d = step_q;
    busy_d = busy_q;
    if (start_i && !busy_q) begin
      rem_d  = num_adj;
      dsh_d  = NUM_W'(den_i) << (DIV_STEPS - 1);
      quo_d  = '0;
      step_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      step_d = step_q + 4'd1;
      if (step_q < 4'(DIV_STEPS)) begin
        if (rem_q >= dsh_q) begin
          rem_d = rem_q - dsh_q;
          quo_d = {quo_q[DUTY_W-2:0], 1'b1};
        end else begin
          quo_d = {quo_q[DUTY_W-2:0], 1'b0};
        end
        dsh_d = dsh_q >> 1;
      end
      if (step_q == 4'(DIV_LAT - 1)) begin
        busy_d = 1'b0;
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dsh_q  <= dsh_d;
      quo_q  <= quo_d;
      step_q <= step_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (step_q == 4'(DIV_STEPS));
  assign quo_o  = clamp_duty(quo_q);

endmodule

// File: rtl/duty_measure.sv
// rtl/duty_measure.sv - duty-cycle meter (0..100 %) with DC timeout; rounding via DUTY_ROUND_EN in duty_div
module duty_measure
  import duty_pkg::*;
#(
  parameter int CNT_W       = 26,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              sig_in,
  output logic [DUTY_W-1:0] duty_bin,
  output logic              duty_valid,
  output logic              dc_flag
);

  localparam int NUM_W = CNT_W + 7;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q, sync_prev_q;
  logic [CNT_W-1:0]  high_q, high_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              valid_q, valid_d;
  logic              dc_q, dc_d;

  logic              rise_det, period_sat, to_hit, static_evt;
  logic              div_start, div_busy, div_done;
  logic [DUTY_W-1:0] div_quo;
  logic [NUM_W-1:0]  div_num;

  assign rise_det   = sync2_q & ~sync_prev_q;
  assign period_sat = &period_q;
  // Fires once, in the cycle the counter reaches TIMEOUT_CYC; a coincident edge wins
  assign to_hit     = !rise_det && (to_q == TO_W'(TIMEOUT_CYC - 1));
  assign div_num    = NUM_W'(high_q) * NUM_W'(DUTY_MAX);

  duty_div #(.CNT_W(CNT_W)) u_div (
    .clk_i   (clk_50M),
    .rst_ni  (rst),
    .start_i (div_start),
    .num_i   (div_num),
    .den_i   (period_q),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quo_o   (div_quo)
  );

  // Next-state: FSM, saturating counters, timeout and output update selection
  always_comb begin
    state_d    = state_q;
    high_d     = high_q;
    period_d   = period_q;
    to_d       = to_q;
    duty_d     = duty_q;
    valid_d    = 1'b0;
    dc_d       = dc_q;
    div_start  = 1'b0;
    static_evt = 1'b0;

    if (rise_det) begin
      to_d = '0;
    end else if (to_q != TO_W'(TIMEOUT_CYC)) begin
      to_d = to_q + 1'b1;
    end

    case (state_q)
      S_WAIT: begin
        if (rise_det) begin
          state_d  = S_RUN;
          period_d = CNT_W'(1);
          high_d   = CNT_W'(1);
        end
      end
      S_RUN: begin
        if (rise_det) begin
          // The edge cycle is the first cycle of the new period (and is high)
          period_d = CNT_W'(1);
          high_d   = CNT_W'(1);
          if (period_sat) begin
            state_d    = S_WAIT;
            static_evt = 1'b1;
          end else if (!div_busy) begin
            div_start = 1'b1;
          end
        end else begin
          if (!period_sat) period_d = period_q + 1'b1;
          if (sync2_q && !(&high_q)) high_d = high_q + 1'b1;
        end
      end
      default: state_d = S_WAIT;
    endcase

    if (to_hit) begin
      state_d    = S_WAIT;
      static_evt = 1'b1;
    end

    if (static_evt) begin
      duty_d  = sync2_q ? DUTY_W'(DUTY_MAX) : '0;
      dc_d    = 1'b1;
      valid_d = 1'b1;
    end else if (div_done && state_q == S_RUN) begin
      duty_d  = div_quo;
      dc_d    = 1'b0;
      valid_d = 1'b1;
    end
  end

  // State, synchroniser, counters and registered outputs
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      state_q     <= S_WAIT;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
      high_q      <= '0;
      period_q    <= '0;
      to_q        <= '0;
      duty_q      <= '0;
      valid_q     <= 1'b0;
      dc_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sig_in;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
      high_q      <= high_d;
      period_q    <= period_d;
      to_q        <= to_d;
      duty_q      <= duty_d;
      valid_q     <= valid_d;
      dc_q        <= dc_d;
    end
  end

  assign duty_bin   = duty_q;
  assign duty_valid = valid_q;
  assign dc_flag    = dc_q;

endmodule

// File: tb/tb_duty_measure.sv
// tb/tb_duty_measure.sv - directed self-checking bench for duty_measure (DUTY_ROUND_EN aware)
module tb_duty_measure;

  localparam int CNT_W = 26;
  localparam int TO    = 1000;

`ifdef DUTY_ROUND_EN
  localparam int EXP_20_30 = 67;
  localparam int EXP_7_9   = 78;
  localparam int EXP_999   = 100;
`else
  localparam int EXP_20_30 = 66;
  localparam int EXP_7_9   = 77;
  localparam int EXP_999   = 99;
`endif

  logic       clk_50M = 1'b0;
  logic       rst     = 1'b0;
  logic       sig_in  = 1'b0;
  logic [6:0] duty_bin;
  logic       duty_valid;
  logic       dc_flag;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int width_err = 0;
  logic prev_valid = 1'b0;

  int v_val[$], v_dc[$], v_cyc[$];
  int e_val[$], e_dc[$], e_cyc[$];
  int rise[$];

  duty_measure #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .sig_in     (sig_in),
    .duty_bin   (duty_bin),
    .duty_valid (duty_valid),
    .dc_flag    (dc_flag)
  );

  always #10 clk_50M = ~clk_50M;

  always @(posedge clk_50M) cyc <= cyc + 1;

  always @(negedge clk_50M) begin
    if (duty_valid) begin
      v_val.push_back(int'(duty_bin));
      v_dc.push_back(int'(dc_flag));
      v_cyc.push_back(cyc);
    end
    if (duty_valid && prev_valid) width_err++;
    prev_valid <= duty_valid;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic run_wave(input int h, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      rise.push_back(cyc);
      sig_in = 1'b1;
      repeat (h) tick();
      sig_in = 1'b0;
      repeat (p - h) tick();
    end
  endtask

  task automatic idle(input int n);
    sig_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_log();
    v_val.delete(); v_dc.delete(); v_cyc.delete(); rise.delete();
  endtask

  task automatic do_reset();
    sig_in = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    clear_log();
  endtask

  task automatic expect_pulse(input int val, input int dc, input int at);
    e_val.push_back(val); e_dc.push_back(dc); e_cyc.push_back(at);
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_count"}, v_val.size(), e_val.size());
    for (int i = 0; i < e_val.size() && i < v_val.size(); i++) begin
      check_eq($sformatf("%s_val%0d", tag, i), v_val[i], e_val[i]);
      check_eq($sformatf("%s_dc%0d", tag, i), v_dc[i], e_dc[i]);
      check_eq($sformatf("%s_cyc%0d", tag, i), v_cyc[i], e_cyc[i]);
    end
    e_val.delete(); e_dc.delete(); e_cyc.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check_eq("rst_duty", int'(duty_bin), 0);
    check_eq("rst_valid", int'(duty_valid), 0);
    check_eq("rst_dc", int'(dc_flag), 0);
    rst = 1'b1;
    repeat (2) tick();
    clear_log();

    // 25 % square wave, period 100
    run_wave(25, 100, 4);
    idle(20);
    for (int k = 1; k <= 3; k++) expect_pulse(25, 0, rise[k] + 11);
    check_log("sq25");
    check_eq("sq25_hold", int'(duty_bin), 25);
    check_eq("sq25_dc", int'(dc_flag), 0);

    // Static high after last edge, then recovery clears dc_flag
    do_reset();
    run_wave(25, 100, 2);
    rise.push_back(cyc);
    sig_in = 1'b1;
    repeat (1200) tick();
    expect_pulse(25, 0, rise[1] + 11);
    expect_pulse(25, 0, rise[2] + 11);
    expect_pulse(100, 1, rise[2] + 1003);
    check_log("dc_hi");
    check_eq("dc_hi_duty", int'(duty_bin), 100);
    check_eq("dc_hi_flag", int'(dc_flag), 1);
    idle(10);
    clear_log();
    run_wave(25, 100, 3);
    idle(20);
    expect_pulse(25, 0, rise[1] + 11);
    expect_pulse(25, 0, rise[2] + 11);
    check_log("recover");
    check_eq("recover_dc", int'(dc_flag), 0);

    // Static low after last edge
    do_reset();
    run_wave(25, 100, 2);
    idle(1200);
    expect_pulse(25, 0, rise[1] + 11);
    expect_pulse(0, 1, rise[1] + 1003);
    check_log("dc_lo");

    // Period 30/20, then period 3/2 (edges inside the busy window are dropped)
    do_reset();
    run_wave(20, 30, 3);
    run_wave(2, 3, 12);
    idle(20);
    expect_pulse(EXP_20_30, 0, rise[1] + 11);
    expect_pulse(EXP_20_30, 0, rise[2] + 11);
    expect_pulse(EXP_20_30, 0, rise[3] + 11);
    expect_pulse(EXP_20_30, 0, rise[7] + 11);
    expect_pulse(EXP_20_30, 0, rise[11] + 11);
    check_log("p3");

    // Minimum period 10 (high 7), then period 9 drops every other edge
    do_reset();
    run_wave(7, 10, 5);
    run_wave(7, 9, 6);
    idle(20);
    for (int k = 1; k <= 5; k++) expect_pulse(70, 0, rise[k] + 11);
    expect_pulse(EXP_7_9, 0, rise[7] + 11);
    expect_pulse(EXP_7_9, 0, rise[9] + 11);
    check_log("p10");

    // Reset in the middle of a division
    do_reset();
    run_wave(25, 100, 3);
    rise.push_back(cyc);
    sig_in = 1'b1;
    repeat (6) tick();
    rst = 1'b0;
    #1;
    check_eq("midrst_duty", int'(duty_bin), 0);
    check_eq("midrst_valid", int'(duty_valid), 0);
    check_eq("midrst_dc", int'(dc_flag), 0);
    expect_pulse(25, 0, rise[1] + 11);
    expect_pulse(25, 0, rise[2] + 11);
    check_log("pre_rst");
    sig_in = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    clear_log();
    idle(20);
    check_eq("midrst_quiet", v_val.size(), 0);
    clear_log();
    run_wave(25, 100, 2);
    idle(20);
    expect_pulse(25, 0, rise[1] + 11);
    check_log("post_rst");

    // Near-100 % and near-0 % at period 1000 (edge coincides with timeout)
    do_reset();
    run_wave(999, 1000, 3);
    run_wave(1, 1000, 3);
    idle(20);
    for (int k = 1; k <= 3; k++) expect_pulse(EXP_999, 0, rise[k] + 11);
    expect_pulse(0, 0, rise[4] + 11);
    expect_pulse(0, 0, rise[5] + 11);
    expect_pulse(0, 1, rise[5] + 1003);
    check_log("extreme");

    check_eq("valid_width", width_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
